next_pc_unit: RTL and testbench

- Registered program-counter unit; successor to the two-way jump select.
- Holds the PC register and picks the next PC from five sources by fixed priority: exception, jump-register, jump, branch, sequential.
- Supports a pipeline stall and latches redirects that arrive while stalled, so none are lost.
- Sits at the front of fetch and drives instruction-memory address and PC+INCR to decode.

---
 rtl/pc_pkg.sv | 17 +
 rtl/next_pc_unit_if.sv | 29 ++
 rtl/next_pc_prio_sel.sv | 54 +++++
 rtl/next_pc_unit.sv | 116 +++++++++++
 tb/tb_next_pc_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC unit: redirect class encodings and
// default vectors. Classes are ordered so a numerically larger class has
// higher priority, which lets the selector compare them directly.
package pc_pkg;

  typedef logic [2:0] pc_cls_t;

  localparam pc_cls_t CLS_SEQ = 3'd0;
  localparam pc_cls_t CLS_BR  = 3'd1;
  localparam pc_cls_t CLS_JMP = 3'd2;
  localparam pc_cls_t CLS_JR  = 3'd3;
  localparam pc_cls_t CLS_EXC = 3'd4;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/next_pc_unit_if.sv
// Fetch-front bus between the redirect sources (master) and the next-PC
// unit (slave): stall and redirect requests in, PC and status out.
interface next_pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jump;
  logic [WIDTH-1:0] jump_addr;
  logic             jr;
  logic [WIDTH-1:0] jr_addr;
  logic             exc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_incr;
  logic             redirect;
  logic             pend_valid;
  logic             misalign;

  modport master (
    output stall, br_taken, br_target, jump, jump_addr, jr, jr_addr, exc,
    input  pc, pc_plus_incr, redirect, pend_valid, misalign
  );

  modport slave (
    input  stall, br_taken, br_target, jump, jump_addr, jr, jr_addr, exc,
    output pc, pc_plus_incr, redirect, pend_valid, misalign
  );
endinterface

// File: rtl/next_pc_prio_sel.sv
// Combinational priority selector: ranks this cycle's requests into a
// current class/target, then arbitrates it against the pending redirect.
// The current request wins ties so a fresh target supersedes a stale one.
module next_pc_prio_sel
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             exc,
  input  pc_cls_t          pend_cls,
  input  logic [WIDTH-1:0] pend_tgt,
  input  logic [WIDTH-1:0] seq_tgt,
  output pc_cls_t          cur_cls,
  output logic [WIDTH-1:0] cur_tgt,
  output pc_cls_t          sel_cls,
  output logic [WIDTH-1:0] sel_tgt
);

  // Rank current requests, then pick the higher of current and pending.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    cur_cls = CLS_SEQ;
    cur_tgt = seq_tgt;
    if (exc) begin
      cur_cls = CLS_EXC;
      cur_tgt = EXC_VECTOR;
    end else if (jr) begin
      cur_cls = CLS_JR;
      cur_tgt = jr_addr;
    end else if (jump) begin
      cur_cls = CLS_JMP;
      cur_tgt = jump_addr;
    end else if (br_taken) begin
      cur_cls = CLS_BR;
      cur_tgt = br_target;
    end

    if (cur_cls >= pend_cls) begin
      sel_cls = cur_cls;
      sel_tgt = cur_tgt;
    end else begin
      sel_cls = pend_cls;
      sel_tgt = pend_tgt;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Registered program-counter unit. Holds pc, a single pending-redirect
// slot that captures requests arriving during a stall, and the redirect
// and misalign pulse registers.
// Optional feature macro: PC_ALIGN_CHECK_EN -- when defined, misaligned
// non-sequential, non-exception targets are replaced by EXC_VECTOR and
// flagged on misalign; when undefined, targets load verbatim and
// misalign is tied low.
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               INCR         = 4
) (
  input  logic          clk,
  input  logic          reset,
  next_pc_unit_if.slave bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_tgt_q;
  pc_cls_t          pend_cls_q;
  logic             pend_valid_q;
  logic             redirect_q;

  pc_cls_t          cur_cls;
  logic [WIDTH-1:0] cur_tgt;
  pc_cls_t          sel_cls;
  logic [WIDTH-1:0] sel_tgt;
  logic [WIDTH-1:0] seq_tgt;
  logic [WIDTH-1:0] load_tgt;
  logic             bad_align;

  // Wraps modulo 2^WIDTH by construction.
  assign seq_tgt = pc_q + WIDTH'(INCR);

  next_pc_prio_sel #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_prio_sel (
    .br_taken  (bus.br_taken),
    .br_target (bus.br_target),
    .jump      (bus.jump),
    .jump_addr (bus.jump_addr),
    .jr        (bus.jr),
    .jr_addr   (bus.jr_addr),
    .exc       (bus.exc),
    .pend_cls  (pend_cls_q),
    .pend_tgt  (pend_tgt_q),
    .seq_tgt   (seq_tgt),
    .cur_cls   (cur_cls),
    .cur_tgt   (cur_tgt),
    .sel_cls   (sel_cls),
    .sel_tgt   (sel_tgt)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;

  // Misaligned redirect targets (pending ones included) become exceptions.
  assign bad_align = (sel_cls != CLS_SEQ) && (sel_cls != CLS_EXC) &&
                     (sel_tgt[1:0] != 2'b00);
  assign load_tgt  = bad_align ? EXC_VECTOR : sel_tgt;

  // One-cycle misalign pulse on the edge that loads the replacement vector.
  always_ff @(posedge clk) begin
    if (reset)          misalign_q <= 1'b0;
    else if (bus.stall) misalign_q <= 1'b0;
    else                misalign_q <= bad_align;
  end

  assign bus.misalign = misalign_q;
`else
  assign bad_align    = 1'b0;
  assign load_tgt     = sel_tgt;
  assign bus.misalign = 1'b0;
`endif

  // PC, pending-class and redirect-pulse registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      pend_cls_q   <= CLS_SEQ;
      pend_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else if (!bus.stall) begin
      pc_q         <= load_tgt;
      pend_cls_q   <= CLS_SEQ;
      pend_valid_q <= 1'b0;
      redirect_q   <= (sel_cls != CLS_SEQ);
    end else begin
      redirect_q   <= 1'b0;
      if (cur_cls != CLS_SEQ && cur_cls >= pend_cls_q) begin
        pend_cls_q   <= cur_cls;
        pend_valid_q <= 1'b1;
      end
    end
  end

  // Pending target captured alongside its class while stalled.
  always_ff @(posedge clk) begin
    // NOTE: the target datapath needs no reset; it is only consumed when
    // pend_cls_q is non-SEQ, and that class register is reset.
    if (bus.stall && cur_cls != CLS_SEQ && cur_cls >= pend_cls_q)
      pend_tgt_q <= cur_tgt;
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus_incr = seq_tgt;
  assign bus.redirect     = redirect_q;
  assign bus.pend_valid   = pend_valid_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (default parameters).
// Inputs change after the #1 that follows each rising edge; outputs are
// sampled at the same point, away from the edge.
module tb_next_pc_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  next_pc_unit_if #(.WIDTH(32)) bus ();

  next_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.br_taken = 0; bus.jump = 0; bus.jr = 0; bus.exc = 0;
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp);
    checks++;
    if (bus.pc !== exp) begin
      errors++;
      $display("FAIL %s: pc=%h expected %h", name, bus.pc, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    bus.br_target = 32'h0; bus.jump_addr = 32'h0; bus.jr_addr = 32'h0;
    reset = 1;
    tick();
    chk_pc("reset_pc", 32'h0);
    chk_bit("reset_redirect", bus.redirect, 1'b0);
    chk_bit("reset_pend", bus.pend_valid, 1'b0);
    chk_bit("reset_misalign", bus.misalign, 1'b0);
    reset = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    exp = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = exp + 32'd4;
      chk_pc("seq_pc", exp);
      chk_bit("seq_redirect", bus.redirect, 1'b0);
    end
    checks++;
    if (bus.pc_plus_incr !== 32'h10) begin
      errors++;
      $display("FAIL seq_plus_incr: got %h expected %h", bus.pc_plus_incr, 32'h10);
    end
    tick();
    chk_pc("seq_to_10", 32'h10);
  endtask

  task automatic test_priority();
    bus.br_taken = 1; bus.br_target = 32'h40;
    bus.jump = 1; bus.jump_addr = 32'h80;
    tick();
    chk_pc("prio_jump_over_br", 32'h80);
    chk_bit("prio_redirect", bus.redirect, 1'b1);
    idle();
    tick();
    chk_pc("prio_after", 32'h84);
    chk_bit("prio_redirect_drop", bus.redirect, 1'b0);
  endtask

  task automatic test_stall_pending();
    bus.stall = 1; bus.br_taken = 1; bus.br_target = 32'h40;
    tick();
    chk_pc("stall1_hold", 32'h84);
    chk_bit("stall1_pend", bus.pend_valid, 1'b1);
    chk_bit("stall1_redirect", bus.redirect, 1'b0);
    bus.br_taken = 0; bus.jr = 1; bus.jr_addr = 32'h200;
    tick();
    chk_pc("stall2_hold", 32'h84);
    chk_bit("stall2_pend", bus.pend_valid, 1'b1);
    bus.jr = 0;
    tick();
    chk_pc("stall3_hold", 32'h84);
    bus.stall = 0;
    tick();
    chk_pc("release_jr", 32'h200);
    chk_bit("release_pend", bus.pend_valid, 1'b0);
    chk_bit("release_redirect", bus.redirect, 1'b1);
  endtask

  task automatic test_pend_hold();
    // Lower-class request during stall must not overwrite a pending JR.
    bus.stall = 1; bus.jr = 1; bus.jr_addr = 32'h300;
    tick();
    bus.jr = 0; bus.br_taken = 1; bus.br_target = 32'h40;
    tick();
    bus.br_taken = 0; bus.stall = 0;
    tick();
    chk_pc("pend_hold_jr", 32'h300);
    // Tie at release: current BR beats pending BR.
    bus.stall = 1; bus.br_taken = 1; bus.br_target = 32'h40;
    tick();
    bus.stall = 0; bus.br_target = 32'h60;
    tick();
    chk_pc("tie_current_wins", 32'h60);
    idle();
  endtask

  task automatic test_exc_override();
    bus.stall = 1; bus.jr = 1; bus.jr_addr = 32'h200;
    tick();
    bus.jr = 0; bus.stall = 0; bus.exc = 1;
    tick();
    chk_pc("exc_over_pend", 32'h80);
    chk_bit("exc_pend_clear", bus.pend_valid, 1'b0);
    bus.exc = 0;
    tick();
    chk_pc("exc_pend_discard", 32'h84);
  endtask

  task automatic test_wrap();
    bus.jump = 1; bus.jump_addr = 32'hFFFF_FFFC;
    tick();
    chk_pc("wrap_load", 32'hFFFF_FFFC);
    checks++;
    if (bus.pc_plus_incr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_plus_incr: got %h expected %h", bus.pc_plus_incr, 32'h0);
    end
    bus.jump = 0;
    tick();
    chk_pc("wrap_zero", 32'h0);
    chk_bit("wrap_no_redirect", bus.redirect, 1'b0);
  endtask

  task automatic test_reset_mid_stall();
    bus.stall = 1; bus.jump = 1; bus.jump_addr = 32'h300;
    tick();
    chk_bit("mid_pend_set", bus.pend_valid, 1'b1);
    reset = 1;
    tick();
    chk_pc("mid_reset_pc", 32'h0);
    chk_bit("mid_reset_pend", bus.pend_valid, 1'b0);
    reset = 0; idle();
    tick();
    chk_pc("mid_reset_discard", 32'h4);
  endtask

  task automatic test_align();
    bus.jump = 1; bus.jump_addr = 32'h102;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    chk_pc("align_replace", 32'h80);
    chk_bit("align_misalign", bus.misalign, 1'b1);
`else
    chk_pc("align_verbatim", 32'h102);
    chk_bit("align_misalign", bus.misalign, 1'b0);
`endif
    chk_bit("align_redirect", bus.redirect, 1'b1);
    bus.jump = 0;
    tick();
    chk_bit("align_pulse_drop", bus.misalign, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_priority();
    test_stall_pending();
    test_pend_hold();
    test_exc_override();
    test_wrap();
    test_reset_mid_stall();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
